// File: rtl/cnu_decode_sched.sv
// Layered CNU decode scheduler: load, LUT read, write-back wait, iteration step.
// Optional early termination on syndrome pass: define CNU_SCHED_EARLY_TERM_EN.
module cnu_decode_sched #(
  parameter int MAX_ITER  = 10,
  parameter int ITER_W    = 4,
  parameter int LAYER_NUM = 4,
  parameter int LAYER_W   = 2,
  parameter int RD_LAT    = 3,
  parameter int WDOG_CYC  = 64,
  parameter int WDOG_W    = 7
) (
  input  logic               read_clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic               cnu_wr_i,
  input  logic               init_load_i,
  input  logic               pipe_load_i,
  input  logic               syndrome_pass_i,
  output logic               cnu_init_load_en_o,
  output logic               cnu_rd_finish_o,
  output logic               iter_update_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               converged_o,
  output logic               timeout_o,
  output logic [ITER_W-1:0]  iter_cnt_o,
  output logic [LAYER_W-1:0] layer_cnt_o
);

  localparam int RD_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INIT_LOAD,
    READ,
    WR_WAIT,
    ITER_UP,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [RD_W-1:0]    rd_q, rd_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic               seen_q, seen_d;
  logic [ITER_W-1:0]  iter_d;
  logic [LAYER_W-1:0] layer_d;
  logic               conv_d, tmo_d;
  logic               conv_hit;
  logic               wdog_hit;
  logic               unused_pipe;

  // pipe_load_i is informational only; it never gates a transition
  assign unused_pipe = pipe_load_i;

`ifdef CNU_SCHED_EARLY_TERM_EN
  assign conv_hit = syndrome_pass_i;
`else
  logic unused_syn;
  assign unused_syn = syndrome_pass_i;
  assign conv_hit   = 1'b0;
`endif

  assign wdog_hit = (wdog_q + WDOG_W'(1)) == WDOG_W'(WDOG_CYC);

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wdog_d  = '0;
    seen_d  = 1'b0;
    iter_d  = iter_cnt_o;
    layer_d = layer_cnt_o;
    conv_d  = converged_o;
    tmo_d   = timeout_o;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = INIT_LOAD;
          iter_d  = '0;
          layer_d = '0;
          conv_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      INIT_LOAD: begin
        if (wdog_hit) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end else if (init_load_i) begin
          state_d = READ;
          rd_d    = '0;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      READ: begin
        if (rd_q == RD_W'(RD_LAT - 1)) begin
          state_d = WR_WAIT;
          rd_d    = '0;
        end else begin
          rd_d = rd_q + RD_W'(1);
        end
      end
      WR_WAIT: begin
        if (wdog_hit) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end else if (seen_q && !cnu_wr_i) begin
          if (layer_cnt_o < LAYER_W'(LAYER_NUM - 1)) begin
            layer_d = layer_cnt_o + LAYER_W'(1);
            state_d = READ;
          end else begin
            layer_d = '0;
            state_d = ITER_UP;
          end
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
          seen_d = seen_q | cnu_wr_i;
        end
      end
      ITER_UP: begin
        if (conv_hit) begin
          state_d = DONE;
          conv_d  = 1'b1;
        end else if (iter_cnt_o == ITER_W'(MAX_ITER - 1)) begin
          state_d = DONE;
        end else begin
          iter_d  = iter_cnt_o + ITER_W'(1);
          state_d = READ;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they align with the state register
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      state_q            <= IDLE;
      rd_q               <= '0;
      wdog_q             <= '0;
      seen_q             <= 1'b0;
      iter_cnt_o         <= '0;
      layer_cnt_o        <= '0;
      converged_o        <= 1'b0;
      timeout_o          <= 1'b0;
      cnu_init_load_en_o <= 1'b0;
      cnu_rd_finish_o    <= 1'b0;
      iter_update_o      <= 1'b0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
    end else begin
      state_q            <= state_d;
      rd_q               <= rd_d;
      wdog_q             <= wdog_d;
      seen_q             <= seen_d;
      iter_cnt_o         <= iter_d;
      layer_cnt_o        <= layer_d;
      converged_o        <= conv_d;
      timeout_o          <= tmo_d;
      cnu_init_load_en_o <= (state_d == INIT_LOAD);
      cnu_rd_finish_o    <= (state_d == WR_WAIT);
      iter_update_o      <= (state_d == ITER_UP);
      busy_o             <= (state_d != IDLE);
      done_o             <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_cnu_decode_sched.sv
// Directed bench for cnu_decode_sched with a handshake responder and
// an expected-result queue popped on each done pulse.
module tb_cnu_decode_sched;

  logic       read_clk;
  logic       rstn;
  logic       start_i;
  logic       cnu_wr_i;
  logic       init_load_i;
  logic       pipe_load_i;
  logic       syndrome_pass_i;
  logic       cnu_init_load_en_o;
  logic       cnu_rd_finish_o;
  logic       iter_update_o;
  logic       busy_o;
  logic       done_o;
  logic       converged_o;
  logic       timeout_o;
  logic [3:0] iter_cnt_o;
  logic [1:0] layer_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int iter;
    int conv;
    int tmo;
    int iu;
    int exits;
    int fin;
  } exp_t;

  exp_t sb[$];

  cnu_decode_sched #(
    .MAX_ITER (2),
    .ITER_W   (4),
    .LAYER_NUM(4),
    .LAYER_W  (2),
    .RD_LAT   (3),
    .WDOG_CYC (64),
    .WDOG_W   (7)
  ) dut (
    .read_clk          (read_clk),
    .rstn              (rstn),
    .start_i           (start_i),
    .cnu_wr_i          (cnu_wr_i),
    .init_load_i       (init_load_i),
    .pipe_load_i       (pipe_load_i),
    .syndrome_pass_i   (syndrome_pass_i),
    .cnu_init_load_en_o(cnu_init_load_en_o),
    .cnu_rd_finish_o   (cnu_rd_finish_o),
    .iter_update_o     (iter_update_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .converged_o       (converged_o),
    .timeout_o         (timeout_o),
    .iter_cnt_o        (iter_cnt_o),
    .layer_cnt_o       (layer_cnt_o)
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  task automatic tick;
    @(posedge read_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_init_en"}, cnu_init_load_en_o, 0);
    chk({tag, "_rd_fin"}, cnu_rd_finish_o, 0);
    chk({tag, "_iter_up"}, iter_update_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_conv"}, converged_o, 0);
    chk({tag, "_tmo"}, timeout_o, 0);
    chk({tag, "_iter"}, iter_cnt_o, 0);
    chk({tag, "_layer"}, layer_cnt_o, 0);
  endtask

  // wr_delay: 0 = strobe already high from READ, N = rises N-th WR_WAIT cycle
  task automatic run(input string tag, input int wr_delay, input bit pass,
                     input bit inject, input int stop_layer,
                     output int n_iu, output int n_done,
                     output int n_exit, output int n_fin);
    int  wt;
    bit  prev_fin;
    bit  is_read;
    n_iu = 0; n_done = 0; n_exit = 0; n_fin = 0;
    wt = 0; prev_fin = 0;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    chk({tag, "_start_conv"}, converged_o, 0);
    chk({tag, "_start_tmo"}, timeout_o, 0);
    chk({tag, "_start_iter"}, iter_cnt_o, 0);
    chk({tag, "_start_layer"}, layer_cnt_o, 0);
    chk({tag, "_start_init_en"}, cnu_init_load_en_o, 1);
    for (int c = 0; c < 400; c++) begin
      is_read = busy_o && !cnu_init_load_en_o && !cnu_rd_finish_o &&
                !iter_update_o && !done_o;
      if (iter_update_o) n_iu++;
      if (cnu_rd_finish_o) begin
        n_fin++;
        wt++;
      end else begin
        wt = 0;
      end
      if (prev_fin && !cnu_rd_finish_o && !done_o) n_exit++;
      prev_fin = cnu_rd_finish_o;
      if (stop_layer >= 0 && cnu_rd_finish_o &&
          int'(layer_cnt_o) == stop_layer) begin
        n_done = -1;
        break;
      end
      init_load_i     = cnu_init_load_en_o;
      cnu_wr_i        = (wr_delay > 0 && wt == wr_delay) ||
                        (wr_delay == 0 && (wt == 1 || is_read));
      pipe_load_i     = cnu_wr_i;
      syndrome_pass_i = pass;
      start_i         = inject && (is_read || done_o);
      if (done_o) begin
        n_done++;
        break;
      end
      tick;
    end
  endtask

  task automatic finish_run(input string tag, input int n_iu,
                            input int n_done, input int n_exit,
                            input int n_fin);
    exp_t e;
    chk({tag, "_done_seen"}, n_done, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_iter"}, iter_cnt_o, e.iter);
      chk({tag, "_conv"}, converged_o, e.conv);
      chk({tag, "_tmo"}, timeout_o, e.tmo);
      chk({tag, "_iu"}, n_iu, e.iu);
      chk({tag, "_exits"}, n_exit, e.exits);
      chk({tag, "_fin_cyc"}, n_fin, e.fin);
    end
    chk({tag, "_done_rd_fin"}, cnu_rd_finish_o, 0);
    chk({tag, "_done_busy"}, busy_o, 1);
    tick;
    start_i     = 1'b0;
    cnu_wr_i    = 1'b0;
    init_load_i = 1'b0;
    chk({tag, "_after_busy"}, busy_o, 0);
    chk({tag, "_after_done"}, done_o, 0);
    chk({tag, "_hold_iter"}, iter_cnt_o, e.iter);
  endtask

  initial begin
    int iu, dn, ex, fn;
    rstn            = 1'b0;
    start_i         = 1'b0;
    cnu_wr_i        = 1'b0;
    init_load_i     = 1'b0;
    pipe_load_i     = 1'b0;
    syndrome_pass_i = 1'b0;
    repeat (3) tick;
    chk_zero("reset");
    rstn = 1'b1;
    tick;

    sb.push_back('{iter: 1, conv: 0, tmo: 0, iu: 2, exits: 8, fin: 16});
    run("nominal", 1, 1'b0, 1'b0, -1, iu, dn, ex, fn);
    finish_run("nominal", iu, dn, ex, fn);

    sb.push_back('{iter: 1, conv: 0, tmo: 0, iu: 2, exits: 8, fin: 32});
    run("slow_wr", 3, 1'b0, 1'b0, -1, iu, dn, ex, fn);
    finish_run("slow_wr", iu, dn, ex, fn);

`ifdef CNU_SCHED_EARLY_TERM_EN
    sb.push_back('{iter: 0, conv: 1, tmo: 0, iu: 1, exits: 4, fin: 8});
`else
    sb.push_back('{iter: 1, conv: 0, tmo: 0, iu: 2, exits: 8, fin: 16});
`endif
    run("early", 1, 1'b1, 1'b0, -1, iu, dn, ex, fn);
    finish_run("early", iu, dn, ex, fn);

    sb.push_back('{iter: 0, conv: 0, tmo: 1, iu: 0, exits: 0, fin: 64});
    run("wdog", 1000, 1'b0, 1'b0, -1, iu, dn, ex, fn);
    finish_run("wdog", iu, dn, ex, fn);

    sb.push_back('{iter: 1, conv: 0, tmo: 0, iu: 2, exits: 8, fin: 16});
    run("busy_start", 1, 1'b0, 1'b1, -1, iu, dn, ex, fn);
    finish_run("busy_start", iu, dn, ex, fn);

    run("abort", 1, 1'b0, 1'b0, 2, iu, dn, ex, fn);
    chk("abort_reached_l2", dn, -1);
    chk("abort_pre_rd_fin", cnu_rd_finish_o, 1);
    cnu_wr_i    = 1'b0;
    init_load_i = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk_zero("abort_async");
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_rst_done", done_o, 0);
    end
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_post_done", done_o, 0);
      chk("abort_post_busy", busy_o, 0);
    end

    sb.push_back('{iter: 1, conv: 0, tmo: 0, iu: 2, exits: 8, fin: 16});
    run("wr_preraised", 0, 1'b0, 1'b0, -1, iu, dn, ex, fn);
    finish_run("wr_preraised", iu, dn, ex, fn);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
